// File: rtl/fetch_queue_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect, and decode-side handshake.
// master = fetch unit, slave = surrounding memory/decode environment.
interface fetch_queue_unit_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [15:0]   imem_req_addr;
    logic          imem_resp_valid;
    logic [15:0]   imem_resp_data;
    logic          redirect_valid;
    logic [15:0]   redirect_pc;
    logic          id_valid;
    logic          id_ready;
    logic [15:0]   id_pc;
    logic [15:0]   id_pc_next;
    logic [15:0]   id_instr;
    logic [CW-1:0] q_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_pc, id_pc_next, id_instr, q_count,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_pc, id_pc_next, id_instr, q_count,
        output id_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch with credit-limited outstanding requests, an in-flight PC tag FIFO and a decode queue.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue_unit #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic                clk,
    input logic                reset,
    fetch_queue_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [15:0]   pc_q, pc_d;
    logic [1:0]    out_q, out_d;
    logic [1:0]    disc_q, disc_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [15:0]   tag_mem  [MAX_OUT];
    logic [15:0]   qpc_mem  [DEPTH];
    logic [15:0]   qins_mem [DEPTH];

    logic          req_valid, req_fire;
    logic          resp_fire, keep, byp, push, q_pop;
    logic [15:0]   resp_tag;
    logic          id_valid;
    logic [15:0]   id_pc, id_instr;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit rule: every in-flight request already owns a queue slot, so the queue cannot overflow.
    always_comb begin
        req_valid = !reset && !bus.redirect_valid
                    && (32'(out_q) < 32'(MAX_OUT))
                    && (32'(out_q) + 32'(count_q) < 32'(DEPTH));
        req_fire  = req_valid && bus.imem_req_ready;
        resp_fire = bus.imem_resp_valid && !reset && (out_q != 2'd0);
        resp_tag  = tag_mem[tag_rd_q];
        keep      = resp_fire && (disc_q == 2'd0) && !bus.redirect_valid;
`ifdef FETCH_BYPASS_EN
        byp       = keep && (count_q == '0);
`else
        byp       = 1'b0;
`endif
        push      = keep && !(byp && bus.id_ready);
        q_pop     = (count_q != '0) && bus.id_ready && !reset;
    end

    always_comb begin
        id_valid = 1'b0;
        id_pc    = 16'h0000;
        id_instr = 16'h0000;
        if ((count_q != '0) && !reset) begin
            id_valid = 1'b1;
            id_pc    = qpc_mem[head_q];
            id_instr = qins_mem[head_q];
        end else if (byp) begin
            id_valid = 1'b1;
            id_pc    = resp_tag;
            id_instr = bus.imem_resp_data;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = id_valid;
    assign bus.id_pc          = id_pc;
    assign bus.id_pc_next     = id_valid ? id_pc + 16'd1 : 16'h0000;
    assign bus.id_instr       = id_instr;
    assign bus.q_count        = count_q;

    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q;
        disc_d   = disc_q;
        tag_rd_d = resp_fire ? tag_next(tag_rd_q) : tag_rd_q;
        tag_wr_d = req_fire ? tag_next(tag_wr_q) : tag_wr_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        if (bus.redirect_valid)
            pc_d = bus.redirect_pc;
        else if (req_fire)
            pc_d = pc_q + 16'd1;

        case ({req_fire, resp_fire})
            2'b10:   out_d = out_q + 2'd1;
            2'b01:   out_d = out_q - 2'd1;
            default: out_d = out_q;
        endcase

        // Everything still in flight after this edge belongs to the abandoned path.
        if (bus.redirect_valid)
            disc_d = out_q - {1'b0, resp_fire};
        else if (resp_fire && (disc_q != 2'd0))
            disc_d = disc_q - 2'd1;

        if (bus.redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push)
                tail_d = tail_q + 1'b1;
            if (q_pop)
                head_d = head_q + 1'b1;
            if (push && !q_pop)
                count_d = count_q + 1'b1;
            else if (!push && q_pop)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            out_q    <= 2'd0;
            disc_q   <= 2'd0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            tag_mem[tag_wr_q] <= pc_q;
        if (push) begin
            qpc_mem[tail_q]  <= resp_tag;
            qins_mem[tail_q] <= bus.imem_resp_data;
        end
    end
endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-queue entries (power of 2, min 2).
REQ-002 SHALL have parameter MAX_OUT, default 2, meaning maximum outstanding instruction-memory requests (1 to 3).
REQ-003 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-004 SHALL have clk  input  1  the single clock, with all state updated on the rising edge.
REQ-005 SHALL have reset  input  1  the synchronous, active-high reset.
REQ-006 SHALL have imem_req_valid  output  1  request valid; imem_req_ready  input  1  memory accepts the request; imem_req_addr  output  16  fetch address.
REQ-007 SHALL have imem_resp_valid  input  1  response valid (in-order, never backpressured); imem_resp_data  input  16  instruction word.
REQ-008 SHALL have redirect_valid  input  1  branch/jump redirect; redirect_pc  input  16  new fetch address.
REQ-009 SHALL have id_valid  output  1; id_ready  input  1 (low means decode stalled); id_pc, id_pc_next, id_instr  output  16 each, feeding the IF/ID pipeline register.
REQ-010 SHALL have q_count  output  $clog2(DEPTH)+1  current number of valid queue entries.

Function
REQ-011 SHALL handshake a request when imem_req_valid && imem_req_ready, and the fetch PC SHALL then increment by 1 with 16-bit wrap (16'hFFFF -> 16'h0000).
REQ-012 SHALL assert imem_req_valid only when outstanding < MAX_OUT, outstanding + q_count < DEPTH (credit rule), reset is low and redirect_valid is low.
REQ-013 imem_req_addr SHALL equal the fetch PC, and SHALL hold stable while imem_req_valid is high and imem_req_ready is low.
REQ-014 SHALL tag each accepted request with its PC in an internal in-flight queue of MAX_OUT entries, and SHALL pair each response with the oldest tag.
REQ-015 SHALL write each non-discarded response to the queue as {pc, pc+1, instr}; the credit rule SHALL guarantee the queue never overflows.
REQ-016 SHALL drive the head entry on id_* with id_valid = (q_count != 0), and SHALL pop the entry on id_valid && id_ready.
REQ-017 SHALL support a simultaneous push and pop in one cycle, leaving q_count unchanged.
REQ-018 On redirect_valid, at the next edge, SHALL set the fetch PC to redirect_pc, flush the queue (q_count = 0), and mark every in-flight request as discarded.
REQ-019 SHALL drop discarded responses, including any response arriving in the redirect cycle; the first response after the drop count reaches zero SHALL belong to the redirect_pc fetch.
REQ-020 SHALL give redirect_valid priority over a pop in the same cycle; the pop still counts as consumed by decode.
REQ-021 SHALL treat a redirect arriving while discards are still pending as resetting the discard count to the then-current outstanding count.
REQ-022 SHALL keep id_pc, id_pc_next and id_instr stable while id_valid && !id_ready.
REQ-023 Without bypass, a response in cycle N SHALL appear on id_* no earlier than cycle N+1.

Reset
REQ-024 While reset is high, SHALL hold fetch PC = RESET_PC, q_count = 0, outstanding = 0, discard count = 0 and imem_req_valid = 0.
REQ-025 While reset is high, SHALL hold id_valid = 0 and id_pc, id_pc_next, id_instr = 16'h0000.
REQ-026 SHALL ignore responses arriving while reset is high.
REQ-027 A reset asserted mid-operation SHALL take priority over redirect, push and pop.
REQ-028 SHALL assert imem_req_valid in the first cycle after reset deasserts.

Configuration
REQ-029 With macro FETCH_BYPASS_EN defined, SHALL forward a non-discarded response arriving while q_count == 0 combinationally to id_*, with id_valid = 1 in the same cycle.
REQ-030 With FETCH_BYPASS_EN defined, a bypassed response accepted by id_ready SHALL not be written to the queue; otherwise it SHALL be pushed.
REQ-031 Without FETCH_BYPASS_EN, SHALL provide no combinational path from imem_resp_* to id_*, and REQ-023 applies.

Verification
REQ-032 Reset, then memory with 1-cycle latency and id_ready = 1 -> addresses 0,1,2,3 are requested; id_pc sequence 0,1,2,3; id_pc_next = id_pc + 1.
REQ-033 DEPTH = 4, id_ready = 0 for 20 cycles -> q_count saturates at 4; no more than 4 requests are accepted; the queue holds PCs 0..3 stable.
REQ-034 Two requests outstanding (PCs 5 and 6), redirect_pc = 16'h0040 -> both responses are dropped; next id_pc = 16'h0040 and q_count = 0 after the redirect.
REQ-035 redirect_pc = 16'hFFFF -> fetch addresses 16'hFFFF then 16'h0000; id_pc_next for 16'hFFFF = 16'h0000.
REQ-036 Reset asserted while q_count = 3 and 2 requests are outstanding -> next cycle id_valid = 0 and q_count = 0; late responses are ignored; fetch restarts at RESET_PC.
REQ-037 With FETCH_BYPASS_EN and the queue empty, response 16'hA5A5 in cycle N -> id_valid = 1 and id_instr = 16'hA5A5 in cycle N. Without the macro, the same response appears in cycle N+1.
